// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               in-order writeback stage and a long-latency unit. Long-latency
//               results are buffered in a small FIFO and drain into cycles the
//               writeback stage leaves idle. A starvation guard stalls
//               writeback for one cycle once the FIFO head has waited MAXWAIT
//               cycles. Pending FIFO destinations are exposed to the hazard
//               unit through q_hit.
// Ports       : clk, rst_n                       clock, async active-low reset
//               wb_regwr/rw/busW/fpoint, wb_ready writeback request + hold
//               ll_valid/rw/data/fpoint, ll_ready long-latency result offer
//               q_rw, q_fpoint, q_hit             hazard destination query
//               rf_we/rw/busW/fpoint              registered write port
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DEPTH   = 2,
  parameter int MAXWAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_regwr,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_busW,
  input  logic [1:0]  wb_fpoint,
  output logic        wb_ready,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rw,
  input  logic [31:0] ll_data,
  input  logic [1:0]  ll_fpoint,
  output logic        ll_ready,
  input  logic [4:0]  q_rw,
  input  logic [1:0]  q_fpoint,
  output logic        q_hit,
  output logic        rf_we,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_busW,
  output logic [1:0]  rf_fpoint
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_ww = $clog2(MAXWAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_ww-1:0]     wait_q, wait_d;
  logic [c_aw:0]       count_q, count_d;
  logic [c_aw-1:0]     wr_ptr_q, rd_ptr_q;

  logic [4:0]          mem_rw_q   [DEPTH];
  logic [31:0]         mem_data_q [DEPTH];
  logic [1:0]          mem_fp_q   [DEPTH];

  logic                w_push, w_pop;
  logic                w_win_valid;
  logic [4:0]          w_win_rw;
  logic [1:0]          w_win_fp;
  logic [31:0]         w_win_data;
  logic [c_ww-1:0]     w_wait_inc;
  logic [DEPTH-1:0]    w_hit_vec;

  // No bypass: a full FIFO refuses even when the head pops this cycle.
  assign ll_ready   = (count_q < (c_aw+1)'(DEPTH));
  assign w_push     = ll_valid && ll_ready;
  assign w_wait_inc = wait_q + c_ww'(1);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    w_pop       = 1'b0;
    wb_ready    = 1'b1;
    w_win_valid = 1'b0;
    w_win_rw    = wb_rw;
    w_win_fp    = wb_fpoint;
    w_win_data  = wb_busW;
    count_d     = count_q;

    case (state_q)
      S_IDLE: begin
        w_win_valid = wb_regwr;
        if (w_push) begin
          state_d = S_PEND;
          wait_d  = '0;
        end
      end
      S_PEND: begin
        if (!wb_regwr) begin
          w_pop = 1'b1;
        end else begin
          w_win_valid = 1'b1;
          wait_d      = w_wait_inc;
          if (w_wait_inc == c_ww'(MAXWAIT)) begin
            state_d = S_FORCE;
          end
        end
      end
      S_FORCE: begin
        wb_ready = 1'b0;
        w_pop    = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase

    if (w_push && !w_pop) begin
      count_d = count_q + (c_aw+1)'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - (c_aw+1)'(1);
    end

    // Any pop hands the port to the FIFO head and restarts its wait window.
    if (w_pop) begin
      w_win_valid = 1'b1;
      w_win_rw    = mem_rw_q[rd_ptr_q];
      w_win_fp    = mem_fp_q[rd_ptr_q];
      w_win_data  = mem_data_q[rd_ptr_q];
      wait_d      = '0;
      state_d     = (count_d == '0) ? S_IDLE : S_PEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + c_aw'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_aw'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q and the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_rw_q[wr_ptr_q]   <= ll_rw;
      mem_fp_q[wr_ptr_q]   <= ll_fpoint;
      mem_data_q[wr_ptr_q] <= ll_data;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [c_aw-1:0] w_offs;
      assign w_offs       = c_aw'(i) - rd_ptr_q;
      assign w_hit_vec[i] = ({1'b0, w_offs} < count_q) &&
                            (mem_rw_q[i] == q_rw) &&
                            ((mem_fp_q[i] != 2'd0) == (q_fpoint != 2'd0));
    end
  endgenerate

  assign q_hit = |w_hit_vec;

  // Integer r0 is hard-wired: its slot is consumed but the enable is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_rw     <= '0;
      rf_busW   <= '0;
      rf_fpoint <= '0;
    end else begin
      rf_we <= w_win_valid && !((w_win_rw == 5'd0) && (w_win_fp == 2'd0));
      if (w_win_valid) begin
        rf_rw     <= w_win_rw;
        rf_busW   <= w_win_data;
        rf_fpoint <= w_win_fp;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed bench for wb_port_arbiter (DEPTH=2, MAXWAIT=4).
//               Stimulus queues every register-file write it expects, in
//               order; a monitor pops and compares each write the DUT makes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  typedef struct packed {
    logic [4:0]  rw;
    logic [1:0]  fp;
    logic [31:0] data;
  } wr_t;

  logic        clk, rst_n;
  logic        wb_regwr, wb_ready;
  logic [4:0]  wb_rw;
  logic [31:0] wb_busW;
  logic [1:0]  wb_fpoint;
  logic        ll_valid, ll_ready;
  logic [4:0]  ll_rw;
  logic [31:0] ll_data;
  logic [1:0]  ll_fpoint;
  logic [4:0]  q_rw;
  logic [1:0]  q_fpoint;
  logic        q_hit;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_busW;
  logic [1:0]  rf_fpoint;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  wb_port_arbiter #(.DEPTH(2), .MAXWAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_regwr(wb_regwr), .wb_rw(wb_rw), .wb_busW(wb_busW),
    .wb_fpoint(wb_fpoint), .wb_ready(wb_ready),
    .ll_valid(ll_valid), .ll_rw(ll_rw), .ll_data(ll_data),
    .ll_fpoint(ll_fpoint), .ll_ready(ll_ready),
    .q_rw(q_rw), .q_fpoint(q_fpoint), .q_hit(q_hit),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_busW(rf_busW), .rf_fpoint(rf_fpoint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rw, input logic [1:0] fp, input logic [31:0] d);
    wr_t e;
    e.rw = rw; e.fp = fp; e.data = d;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus: drive at the falling edge, then check handshakes.
  task automatic drive(input string name,
                       input logic wv, input logic [4:0] wrw, input logic [1:0] wfp,
                       input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrw, input logic [1:0] lfp,
                       input logic [31:0] ld,
                       input logic exp_wr, input logic exp_lr);
    @(negedge clk);
    wb_regwr = wv; wb_rw = wrw; wb_fpoint = wfp; wb_busW = wd;
    ll_valid = lv; ll_rw = lrw; ll_fpoint = lfp; ll_data = ld;
    #1;
    chk({name, "_wb_ready"}, 64'(wb_ready), 64'(exp_wr));
    chk({name, "_ll_ready"}, 64'(ll_ready), 64'(exp_lr));
  endtask

  // Scoreboard monitor: every write the DUT presents must match the queue head.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rf_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got rw=%0d fp=%0d data=%0h expected no write",
                   rf_rw, rf_fpoint, rf_busW);
        end else begin
          e = exp_q.pop_front();
          chk("rf_write", {25'd0, rf_rw, rf_fpoint, rf_busW}, {25'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    wb_regwr = 0; wb_rw = 0; wb_busW = 0; wb_fpoint = 0;
    ll_valid = 0; ll_rw = 0; ll_data = 0; ll_fpoint = 0;
    q_rw = 0; q_fpoint = 0;

    // ---- reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_fields", {25'd0, rf_rw, rf_fpoint, rf_busW}, 64'd0);
    chk("rst_ll_ready", 64'(ll_ready), 64'd1);
    chk("rst_wb_ready", 64'(wb_ready), 64'd1);
    chk("rst_q_hit", 64'(q_hit), 64'd0);
    rst_n = 1'b1;

    // ---- idle drain: pushed in N, written in N+1, visible in N+2
    drive("drain0", 0, 5'd0, 2'd0, 32'h0, 1, 5'd7, 2'd1, 32'hDEADBEEF, 1, 1);
    push_exp(5'd7, 2'd1, 32'hDEADBEEF);
    drive("drain1", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    chk("drain_n1_we", 64'(rf_we), 64'd0);
    drive("drain2", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    chk("drain_n2_we", 64'(rf_we), 64'd1);
    chk("drain_n2_rw", 64'(rf_rw), 64'd7);
    q_rw = 5'd7; q_fpoint = 2'd1; #1;
    chk("drain_q_hit", 64'(q_hit), 64'd0);
    drive("drain3", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    chk("drain_one_cycle", 64'(rf_we), 64'd0);

    // ---- r0 filter: integer r0 dropped, FP f0 written
    drive("r0_int", 1, 5'd0, 2'd0, 32'h1234, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    drive("r0_fp", 1, 5'd0, 2'd2, 32'h1234, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    chk("r0_int_we", 64'(rf_we), 64'd0);
    push_exp(5'd0, 2'd2, 32'h1234);
    drive("r0_end", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    chk("r0_fp_we", 64'(rf_we), 64'd1);
    chk("r0_fp_rw", 64'(rf_rw), 64'd0);

    // ---- hazard query against a pending entry
    drive("qry0", 1, 5'd10, 2'd0, 32'hA, 1, 5'd5, 2'd0, 32'h55, 1, 1);
    push_exp(5'd10, 2'd0, 32'hA);
    drive("qry1", 1, 5'd11, 2'd0, 32'hB, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    push_exp(5'd11, 2'd0, 32'hB);
    q_rw = 5'd5; q_fpoint = 2'd0; #1;
    chk("qry_hit_int", 64'(q_hit), 64'd1);
    q_fpoint = 2'd3; #1;
    chk("qry_miss_fp", 64'(q_hit), 64'd0);
    q_fpoint = 2'd0;
    drive("qry2", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    push_exp(5'd5, 2'd0, 32'h55);
    drive("qry3", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    chk("qry_after_drain", 64'(q_hit), 64'd0);

    // ---- starvation: four writeback wins in PEND, then a one-cycle stall
    for (int t = 0; t < 7; t++) begin
      int idx;
      idx = (t == 6) ? 5 : t;
      drive("starve", 1, 5'(20 + idx), 2'd0, 32'h100 + 32'(idx),
            (t == 0), 5'd3, 2'd0, 32'h33, (t != 5), 1);
      if (t == 5) push_exp(5'd3, 2'd0, 32'h33);
      else        push_exp(5'(20 + idx), 2'd0, 32'h100 + 32'(idx));
    end

    // ---- full FIFO backpressure: third result holds until a pop frees space
    drive("full0", 1, 5'd24, 2'd0, 32'hC0, 1, 5'd12, 2'd0, 32'hE0, 1, 1);
    push_exp(5'd24, 2'd0, 32'hC0);
    drive("full1", 1, 5'd25, 2'd0, 32'hC1, 1, 5'd13, 2'd0, 32'hE1, 1, 1);
    push_exp(5'd25, 2'd0, 32'hC1);
    drive("full2", 1, 5'd26, 2'd0, 32'hC2, 1, 5'd14, 2'd0, 32'hE2, 1, 0);
    push_exp(5'd26, 2'd0, 32'hC2);
    drive("full3", 0, 5'd0, 2'd0, 32'h0, 1, 5'd14, 2'd0, 32'hE2, 1, 0);
    push_exp(5'd12, 2'd0, 32'hE0);
    drive("full4", 0, 5'd0, 2'd0, 32'h0, 1, 5'd14, 2'd0, 32'hE2, 1, 1);
    push_exp(5'd13, 2'd0, 32'hE1);
    drive("full5", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);
    push_exp(5'd14, 2'd0, 32'hE2);
    drive("full6", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);

    // ---- reset with a full FIFO discards the pending entries
    drive("rst0", 1, 5'd28, 2'd0, 32'hD0, 1, 5'd17, 2'd0, 32'hF0, 1, 1);
    push_exp(5'd28, 2'd0, 32'hD0);
    drive("rst1", 1, 5'd29, 2'd0, 32'hD1, 1, 5'd18, 2'd0, 32'hF1, 1, 1);
    push_exp(5'd29, 2'd0, 32'hD1);
    @(negedge clk);
    wb_regwr = 0; ll_valid = 0;
    q_rw = 5'd17; q_fpoint = 2'd0;
    #1;
    chk("prerst_q_hit", 64'(q_hit), 64'd1);
    chk("prerst_ll_ready", 64'(ll_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_we", 64'(rf_we), 64'd0);
    chk("midrst_ll_ready", 64'(ll_ready), 64'd1);
    chk("midrst_q_hit", 64'(q_hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      drive("postrst", 0, 5'd0, 2'd0, 32'h0, 0, 5'd0, 2'd0, 32'h0, 1, 1);
      chk("postrst_no_write", 64'(rf_we), 64'd0);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
